// File: rtl/xuart_tx.sv
// Memory-mapped 8N1 serial transmitter: byte FIFO fed by TXDATA stores, drained LSB first onto tx.
// Optional even-parity bit enabled by defining XUART_TX_PARITY_EN (flag in STATUS bit8).
module xuart_tx #(
    parameter int          DATA_W  = 32,
    parameter int          FIFO_AW = 2,
    parameter logic [15:0] DIV_RST = 16'd434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              tx
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef XUART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    logic par_en;
    logic par_bit;
`endif

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   count;
    logic               ovf;
    logic [15:0]        div, bit_cnt, reload;
    logic [2:0]         state, bit_idx;
    logic [7:0]         shift;
    logic               full, empty, push, push_ok, pop, bit_end;
    logic [DATA_W-1:0]  status;
    logic               unused_data;

    assign full    = (count == (FIFO_AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = sel & we & (addr == 2'd0);
    assign push_ok = push & ~full;
    assign pop     = (state == S_IDLE) & ~empty;
    // A divisor of 0 is treated as 1, so both reload a count of 0.
    assign reload  = (div == 16'd0) ? 16'd0 : div - 16'd1;
    assign bit_end = (bit_cnt == 16'd0);
    assign unused_data = ^data_in;

    always_comb begin
        status      = '0;
        status[0]   = full;
        status[1]   = empty;
        status[2]   = (state != S_IDLE);
        status[3]   = ovf;
        status[7:4] = 4'(count);
`ifdef XUART_TX_PARITY_EN
        status[8]   = par_en;
`endif
    end

    always_comb begin
        data_out = '0;
        if (sel && !we) begin
            case (addr)
                2'd1:    data_out = status;
                2'd2:    data_out = {{(DATA_W-16){1'b0}}, div};
                default: data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            div     <= DIV_RST;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            state   <= S_IDLE;
            tx      <= 1'b1;
`ifdef XUART_TX_PARITY_EN
            par_en  <= 1'b0;
            par_bit <= 1'b0;
`endif
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (push && full) ovf <= 1'b1;
            else if (sel && we && addr == 2'd1) ovf <= 1'b0;
`ifdef XUART_TX_PARITY_EN
            if (sel && we && addr == 2'd1) par_en <= data_in[8];
`endif
            if (sel && we && addr == 2'd2) div <= data_in[15:0];
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rptr];
                        rptr    <= rptr + 1'b1;
                        bit_cnt <= reload;
                        state   <= S_START;
                        tx      <= 1'b0;
`ifdef XUART_TX_PARITY_EN
                        par_bit <= ^mem[rptr];
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_cnt <= reload;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx      <= shift[0];
                    end else bit_cnt <= bit_cnt - 1'b1;
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= reload;
                        shift   <= shift >> 1;
                        if (bit_idx == 3'd7) begin
`ifdef XUART_TX_PARITY_EN
                            state <= par_en ? S_PARITY : S_STOP;
                            tx    <= par_en ? par_bit : 1'b1;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end
                    end else bit_cnt <= bit_cnt - 1'b1;
                end
`ifdef XUART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= reload;
                        state   <= S_STOP;
                        tx      <= 1'b1;
                    end else bit_cnt <= bit_cnt - 1'b1;
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        state <= S_IDLE;
                        tx    <= 1'b1;
                    end else bit_cnt <= bit_cnt - 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
